// File: rtl/calc_alu_seq_if.sv
// Request/result bundle of the sequential calculator ALU.
// master drives requests, slave returns results.
interface calc_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic                   clear;
    logic [4:0]             operador;
    logic [WIDTH-1:0]       operando1;
    logic [WIDTH-1:0]       operando2;
    logic [2*WIDTH-1:0]     resultado;
    logic                   negativo;
    logic                   error;
    logic                   busy;
    logic                   done;

    modport master (
        output start, clear, operador, operando1, operando2,
        input  resultado, negativo, error, busy, done
    );

    modport slave (
        input  start, clear, operador, operando1, operando2,
        output resultado, negativo, error, busy, done
    );
endinterface

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: single-cycle add/sub/and/or,
// shift-add multiply over WIDTH cycles, sign-magnitude result.
module calc_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    calc_alu_seq_if.slave    bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD = 5'h10;
    localparam logic [4:0] OP_SUB = 5'h11;
    localparam logic [4:0] OP_MUL = 5'h12;
    localparam logic [4:0] OP_AND = 5'h14;
    localparam logic [4:0] OP_OR  = 5'h15;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    logic [RW-1:0]    alu_res;
    logic             alu_neg;
    logic             alu_err;
    logic [RW-1:0]    acc_sum;
    logic             mul_last;

    assign acc_sum  = mplier[0] ? acc + mcand : acc;
    assign mul_last = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = (op_q == OP_MUL) ? MUL : IDLE;
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.clear) begin
            state_nxt = IDLE;
        end
    end

    // Single-cycle operations on the latched operands.
    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: alu_res = RW'(a_q) + RW'(b_q);
            OP_SUB: begin
                if (a_q >= b_q) begin
                    alu_res = RW'(a_q - b_q);
                end else begin
                    alu_res = RW'(b_q - a_q);
                    alu_neg = 1'b1;
                end
            end
            OP_AND: alu_res = RW'(a_q & b_q);
            OP_OR:  alu_res = RW'(a_q | b_q);
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Request latch, multiply datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            bus.resultado <= '0;
            bus.negativo  <= 1'b0;
            bus.error     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.operador;
                        a_q      <= bus.operando1;
                        b_q      <= bus.operando2;
                        bus.busy <= 1'b1;
                    end
                end
                EXEC: begin
                    if (op_q == OP_MUL) begin
                        acc    <= '0;
                        mcand  <= RW'(a_q);
                        mplier <= b_q;
                        cnt    <= '0;
                    end else begin
                        bus.resultado <= alu_res;
                        bus.negativo  <= alu_neg;
                        bus.error     <= alu_err;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (mul_last) begin
                        bus.resultado <= acc_sum;
                        bus.negativo  <= 1'b0;
                        bus.error     <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
